pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of saturating performance counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports rs1_IDC, rs2_IDC  input  5 each  source registers of the instruction in IDC.
REQ-005 SHALL have ports is_rs1_used, is_rs2_used  input  1 each  source-register valid qualifiers.
REQ-006 SHALL have ports rd_IDR, rd_EX  input  5 each  destinations of the instructions in IDR and EX.
REQ-007 SHALL have ports dm_rd_ctrl_IDR, dm_rd_ctrl_EX  input  3 each  load control; nonzero means load.
REQ-008 SHALL have port redirect_EX  input  1  taken branch/jump resolved in EX.
REQ-009 SHALL have port dm_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-010 SHALL have ports stall_front, bubble_idr, flush_front, stall_all  output  1 each  IF/IDC hold, NOP into IDR register, IF/IDC squash, global freeze.
REQ-011 SHALL have port state  output  2  FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2).
REQ-012 SHALL have ports stall_cycles, flush_count  output  CNT_W each  saturating performance counters.

Function
REQ-013 SHALL detect a load-use hazard when the IDC operand is used, equals rd of a load, and that rd is nonzero.
REQ-014 SHALL require 2 stall cycles for a match in IDR and 1 for a match in EX; when both match, 2 applies.
REQ-015 SHALL, in RUN on a hazard, assert stall_front and bubble_idr combinationally in the same cycle.
REQ-016 SHALL, for a 2-cycle hazard, enter LU_STALL with remain=1; LU_STALL asserts stall_front and bubble_idr, then returns to RUN.
REQ-017 SHALL, on redirect_EX with dm_busy low, assert flush_front and bubble_idr in the same cycle, deassert stall_front, and force the next state to RUN, abandoning any load-use stall.
REQ-018 SHALL, on dm_busy high, assert stall_all only, with stall_front, bubble_idr and flush_front low, and enter or remain in MEM_WAIT.
REQ-019 SHALL save the pre-freeze state and remain count on entry to MEM_WAIT, and restore them on the first cycle dm_busy is low.
REQ-020 SHALL latch redirect_EX arriving while dm_busy is high into a pending flag, and apply it as in REQ-017 on the first non-busy cycle.
REQ-021 SHALL prioritise dm_busy over redirect (pending or live), and redirect over load-use.
REQ-022 SHALL increment stall_cycles on every cycle with stall_front or stall_all high, saturating at all-ones.
REQ-023 SHALL increment flush_count once per applied redirect, saturating at all-ones.
REQ-024 SHALL treat an operand whose is_rsX_used is low as non-hazardous, whatever the register match.

Reset
REQ-025 SHALL, while reset is low, force state=RUN, remain=0, pending=0, counters=0, and all four control outputs low, asynchronously.
REQ-026 SHALL, when reset is asserted mid-stall or mid-freeze, abandon the saved state, and resume in RUN on the first edge after release.

Structure
REQ-027 SHALL import the state enum, a load-detect helper and CNT_W default from the shared pipeline package pipeline_pkg.
REQ-028 SHALL instantiate one sub-module, sat_counter (parameter width CNT_W, inc, clear), twice.

Verification
REQ-029 SHALL check: lw x5 in IDR, IDC add uses rs1=x5 -> stall_front=bubble_idr=1 for exactly 2 cycles, stall_cycles=2.
REQ-030 SHALL check: rd_IDR=x0 load, IDC uses x0 -> no stall, state stays 0.
REQ-031 SHALL check: redirect_EX pulse during the first LU_STALL cycle -> flush_front=1 that cycle, state=RUN next, stall_front=0, flush_count=1.
REQ-032 SHALL check: dm_busy high 3 cycles during LU_STALL -> stall_all=1 for 3 cycles, state=2, then 1 remaining LU_STALL cycle.
REQ-033 SHALL check: redirect_EX during dm_busy -> no flush while busy, flush_front=1 on the first non-busy cycle.
REQ-034 SHALL check: CNT_W=4, 20 stall cycles -> stall_cycles holds 15; reset low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller FSM states, counter width default and
// a load-detect helper.
package pipeline_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } hz_state_e;

    // Any nonzero data-memory read control marks the instruction as a load.
    function automatic logic is_load(input logic [2:0] dm_rd_ctrl);
        return |dm_rd_ctrl;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute operand info in, pipeline steering and counters out.
interface pipeline_hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic [4:0]       rs1_IDC;
    logic [4:0]       rs2_IDC;
    logic             is_rs1_used;
    logic             is_rs2_used;
    logic [4:0]       rd_IDR;
    logic [4:0]       rd_EX;
    logic [2:0]       dm_rd_ctrl_IDR;
    logic [2:0]       dm_rd_ctrl_EX;
    logic             redirect_EX;
    logic             dm_busy;
    logic             stall_front;
    logic             bubble_idr;
    logic             flush_front;
    logic             stall_all;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_IDC, rs2_IDC, is_rs1_used, is_rs2_used, rd_IDR, rd_EX,
               dm_rd_ctrl_IDR, dm_rd_ctrl_EX, redirect_EX, dm_busy,
        input  stall_front, bubble_idr, flush_front, stall_all, state,
               stall_cycles, flush_count
    );

    modport slave (
        input  rs1_IDC, rs2_IDC, is_rs1_used, is_rs2_used, rd_IDR, rd_EX,
               dm_rd_ctrl_IDR, dm_rd_ctrl_EX, redirect_EX, dm_busy,
        output stall_front, bubble_idr, flush_front, stall_all, state,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch-redirect flush and memory-wait freeze controller for the in-order
// pipeline, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e  state_q, state_d, saved_state_q, saved_state_d, cur_state;
    logic [1:0] remain_q, remain_d, saved_remain_q, saved_remain_d, cur_remain;
    logic       pending_q, pending_d;
    logic       hz_idr, hz_ex, redirect;
    logic       stall_front_c, bubble_c, flush_c, stall_all_c;

    always_comb begin
        hz_idr = is_load(hz.dm_rd_ctrl_IDR) && (hz.rd_IDR != 5'd0) &&
                 ((hz.is_rs1_used && (hz.rs1_IDC == hz.rd_IDR)) ||
                  (hz.is_rs2_used && (hz.rs2_IDC == hz.rd_IDR)));
        hz_ex  = is_load(hz.dm_rd_ctrl_EX) && (hz.rd_EX != 5'd0) &&
                 ((hz.is_rs1_used && (hz.rs1_IDC == hz.rd_EX)) ||
                  (hz.is_rs2_used && (hz.rs2_IDC == hz.rd_EX)));
    end

    always_comb begin
        // The first non-busy cycle after a freeze behaves as the saved pre-freeze state.
        cur_state      = (state_q == StMemWait) ? saved_state_q : state_q;
        cur_remain     = (state_q == StMemWait) ? saved_remain_q : remain_q;
        state_d        = cur_state;
        remain_d       = cur_remain;
        saved_state_d  = saved_state_q;
        saved_remain_d = saved_remain_q;
        pending_d      = pending_q;
        redirect       = hz.redirect_EX || pending_q;
        stall_front_c  = 1'b0;
        bubble_c       = 1'b0;
        flush_c        = 1'b0;
        stall_all_c    = 1'b0;

        if (hz.dm_busy) begin
            stall_all_c = 1'b1;
            state_d     = StMemWait;
            pending_d   = redirect;
            if (state_q != StMemWait) begin
                saved_state_d  = state_q;
                saved_remain_d = remain_q;
            end
        end else if (redirect) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            state_d   = StRun;
            remain_d  = 2'd0;
            pending_d = 1'b0;
        end else begin
            case (cur_state)
                StLuStall: begin
                    stall_front_c = 1'b1;
                    bubble_c      = 1'b1;
                    remain_d      = (cur_remain > 2'd1) ? cur_remain - 2'd1 : 2'd0;
                    state_d       = (cur_remain > 2'd1) ? StLuStall : StRun;
                end
                default: begin
                    state_d = StRun;
                    if (hz_idr) begin
                        stall_front_c = 1'b1;
                        bubble_c      = 1'b1;
                        state_d       = StLuStall;
                        remain_d      = 2'd1;
                    end else if (hz_ex) begin
                        stall_front_c = 1'b1;
                        bubble_c      = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StRun;
            remain_q       <= 2'd0;
            saved_state_q  <= StRun;
            saved_remain_q <= 2'd0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            remain_q       <= remain_d;
            saved_state_q  <= saved_state_d;
            saved_remain_q <= saved_remain_d;
            pending_q      <= pending_d;
        end
    end

    // Gate the decoded controls so they drop the instant reset is asserted.
    assign hz.stall_front = reset & stall_front_c;
    assign hz.bubble_idr  = reset & bubble_c;
    assign hz.flush_front = reset & flush_c;
    assign hz.stall_all   = reset & stall_all_c;
    assign hz.state       = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.stall_front | hz.stall_all),
        .clear (1'b0),
        .count (hz.stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.flush_front),
        .clear (1'b0),
        .count (hz.flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked against a cycle-level behavioural model of stalls owed, pending redirects and counters.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs1, rs2, rdi, rde;
        logic       u1, u2;
        logic [2:0] ci, ce;
        logic       red, busy, rst;
    } stim_t;

    typedef struct packed {
        logic          sf, bi, ff, sa;
        logic [1:0]    st;
        logic [CW-1:0] sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: bubbles still owed, latched redirect, previous cycle frozen.
    int m_owed = 0;
    bit m_pend = 1'b0;
    bit m_prev_busy = 1'b0;
    int m_sc = 0;
    int m_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit load_hits(input stim_t s, input logic [4:0] rd, input logic [2:0] ctl);
        return (ctl != 3'd0) && (rd != 5'd0) &&
               ((s.u1 && s.rs1 == rd) || (s.u2 && s.rs2 == rd));
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   need;
        e = '0;
        if (!s.rst) begin
            m_owed = 0; m_pend = 1'b0; m_prev_busy = 1'b0; m_sc = 0; m_fc = 0;
            return e;
        end
        e.sc = CW'(m_sc);
        e.fc = CW'(m_fc);
        e.st = m_prev_busy ? 2'd2 : ((m_owed > 0) ? 2'd1 : 2'd0);
        // A load one stage ahead (IDR) needs two bubbles, two stages ahead (EX) needs one.
        need = load_hits(s, s.rdi, s.ci) ? 2 : (load_hits(s, s.rde, s.ce) ? 1 : 0);
        if (s.busy) begin
            e.sa = 1'b1;
            m_pend = m_pend | s.red;
            m_prev_busy = 1'b1;
        end else begin
            m_prev_busy = 1'b0;
            if (s.red || m_pend) begin
                e.ff = 1'b1; e.bi = 1'b1;
                m_owed = 0; m_pend = 1'b0;
            end else if (m_owed > 0) begin
                e.sf = 1'b1; e.bi = 1'b1;
                m_owed--;
            end else if (need > 0) begin
                e.sf = 1'b1; e.bi = 1'b1;
                m_owed = need - 1;
            end
        end
        if (e.sf || e.sa) m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
        if (e.ff) m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
        return e;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        reset             = s.rst;
        hz.rs1_IDC        = s.rs1;
        hz.rs2_IDC        = s.rs2;
        hz.is_rs1_used    = s.u1;
        hz.is_rs2_used    = s.u2;
        hz.rd_IDR         = s.rdi;
        hz.rd_EX          = s.rde;
        hz.dm_rd_ctrl_IDR = s.ci;
        hz.dm_rd_ctrl_EX  = s.ce;
        hz.redirect_EX    = s.red;
        hz.dm_busy        = s.busy;
        exp_q.push_back(model(s));
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t lw_idr(input logic [4:0] r);
        stim_t s;
        s = idle();
        s.rdi = r; s.ci = 3'b010; s.rs1 = r; s.u1 = 1'b1; s.rs2 = 5'd9; s.u2 = 1'b1;
        return s;
    endfunction

    // Monitor: one expected response per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_front",  32'(hz.stall_front),  32'(e.sf));
                check("bubble_idr",   32'(hz.bubble_idr),   32'(e.bi));
                check("flush_front",  32'(hz.flush_front),  32'(e.ff));
                check("stall_all",    32'(hz.stall_all),    32'(e.sa));
                check("state",        32'(hz.state),        32'(e.st));
                check("stall_cycles", 32'(hz.stall_cycles), 32'(e.sc));
                check("flush_count",  32'(hz.flush_count),  32'(e.fc));
            end
        end
    end

    initial begin
        stim_t s;
        int    busy_left;
        hz.rs1_IDC = '0; hz.rs2_IDC = '0; hz.is_rs1_used = 1'b0; hz.is_rs2_used = 1'b0;
        hz.rd_IDR = '0; hz.rd_EX = '0; hz.dm_rd_ctrl_IDR = '0; hz.dm_rd_ctrl_EX = '0;
        hz.redirect_EX = 1'b0; hz.dm_busy = 1'b0;

        s = idle(); s.rst = 1'b0;
        step(s); step(s);
        step(idle());

        // lw x5 in IDR, consumer in IDC: two stall cycles.
        step(lw_idr(5'd5));
        s = idle(); s.rde = 5'd5; s.ce = 3'b010; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s);
        step(idle()); step(idle());

        // Load to x0 never stalls; unused operand never stalls.
        s = lw_idr(5'd0); step(s);
        s = lw_idr(5'd6); s.u1 = 1'b0; step(s);
        step(idle());

        // Matches in both IDR and EX: two cycles apply.
        s = lw_idr(5'd3); s.rde = 5'd9; s.ce = 3'b001; step(s);
        step(idle()); step(idle());

        // Redirect during the LU_STALL cycle abandons the stall.
        step(lw_idr(5'd5));
        s = idle(); s.red = 1'b1; step(s);
        step(idle()); step(idle());

        // Memory freeze during LU_STALL, then the remaining stall cycle.
        step(lw_idr(5'd7));
        s = idle(); s.busy = 1'b1;
        step(s); step(s); step(s);
        step(idle()); step(idle());

        // Redirect while busy is held pending until the memory is ready.
        s = idle(); s.busy = 1'b1; s.red = 1'b1; step(s);
        s.red = 1'b0; step(s); step(s);
        step(idle()); step(idle());

        // Stall-counter saturation, then reset mid-stall.
        s = idle(); s.rst = 1'b0; step(s);
        s = idle(); s.rde = 5'd7; s.ce = 3'b100; s.rs2 = 5'd7; s.u2 = 1'b1;
        for (int i = 0; i < 21; i++) step(s);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_stall_front", 32'(hz.stall_front), 32'd0);
        check("async_rst_bubble_idr",  32'(hz.bubble_idr),  32'd0);
        check("async_rst_flush_front", 32'(hz.flush_front), 32'd0);
        check("async_rst_stall_all",   32'(hz.stall_all),   32'd0);
        check("async_rst_state",       32'(hz.state),       32'd0);
        check("async_rst_stall_cnt",   32'(hz.stall_cycles), 32'd0);
        void'(model(idle() & ~stim_t'(1)));
        s.rst = 1'b0; step(s);
        step(idle());

        // Random traffic with narrow register ranges so hazards are frequent.
        busy_left = 0;
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rdi = 5'($urandom_range(0, 3));
            s.rde = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.ci  = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            s.ce  = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            s.red = ($urandom_range(0, 9) == 0);
            if (busy_left > 0) begin
                s.busy = 1'b1;
                busy_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                s.busy = 1'b1;
                busy_left = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 149) == 0) s.rst = 1'b0;
            step(s);
        end

        step(idle());
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
